// File: rtl/fp_int_converter.sv
`default_nettype none
// ============================================================================
// Module      : fp_int_converter
// Description : Iterative int32 <-> fp32 converter, truncating toward zero,
//               one shift per cycle with valid/ready on both sides.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_int_converter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        mode,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_inexact,
    output logic        out_invalid
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_SHIFT = 2'd1;
    localparam logic [1:0] c_DONE  = 2'd2;

    logic [1:0]  r_state;
    logic        r_mode;
    logic        r_sign;
    logic [31:0] r_mag;
    logic [7:0]  r_exp;
    logic [4:0]  r_cnt;
    logic        r_sticky;

    logic        w_sign;
    logic [31:0] w_abs;
    logic [7:0]  w_exp;
    logic [22:0] w_frac;
    logic        w_nan;
    logic        w_int_min;
    logic        w_sat;
    logic        w_small;
    logic [4:0]  w_cnt;
    logic [31:0] w_neg_mag;

    assign w_sign    = in_data[31];
    assign w_abs     = w_sign ? (~in_data + 32'd1) : in_data;
    assign w_exp     = in_data[30:23];
    assign w_frac    = in_data[22:0];
    assign w_nan     = (w_exp == 8'hFF) && (w_frac != 23'd0);
    // -2^31 is the only value with e==158 that fits int32 exactly
    assign w_int_min = w_sign && (w_exp == 8'd158) && (w_frac == 23'd0);
    assign w_sat     = (w_exp >= 8'd158) && !w_int_min;
    assign w_small   = (w_exp < 8'd127);
    assign w_cnt     = 5'(8'd158 - w_exp);
    assign w_neg_mag = ~r_mag + 32'd1;

    assign in_ready  = (r_state == c_IDLE);
    assign out_valid = (r_state == c_DONE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= c_IDLE;
            r_mode      <= 1'b0;
            r_sign      <= 1'b0;
            r_mag       <= 32'd0;
            r_exp       <= 8'd0;
            r_cnt       <= 5'd0;
            r_sticky    <= 1'b0;
            out_data    <= 32'd0;
            out_inexact <= 1'b0;
            out_invalid <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (in_valid) begin
                        r_mode   <= mode;
                        r_sign   <= w_sign;
                        r_sticky <= 1'b0;
                        if (!mode) begin
                            if (in_data == 32'd0) begin
                                out_data    <= 32'd0;
                                out_inexact <= 1'b0;
                                out_invalid <= 1'b0;
                                r_state     <= c_DONE;
                            end else begin
                                r_mag   <= w_abs;
                                r_exp   <= 8'd158;
                                r_state <= c_SHIFT;
                            end
                        end else if (w_nan) begin
                            out_data    <= 32'h8000_0000;
                            out_inexact <= 1'b0;
                            out_invalid <= 1'b1;
                            r_state     <= c_DONE;
                        end else if (w_sat) begin
                            out_data    <= w_sign ? 32'h8000_0000 : 32'h7FFF_FFFF;
                            out_inexact <= 1'b0;
                            out_invalid <= 1'b1;
                            r_state     <= c_DONE;
                        end else if (w_int_min) begin
                            out_data    <= 32'h8000_0000;
                            out_inexact <= 1'b0;
                            out_invalid <= 1'b0;
                            r_state     <= c_DONE;
                        end else if (w_small) begin
                            out_data    <= 32'd0;
                            out_inexact <= (w_exp != 8'd0) || (w_frac != 23'd0);
                            out_invalid <= 1'b0;
                            r_state     <= c_DONE;
                        end else begin
                            r_mag   <= {1'b1, w_frac, 8'd0};
                            r_cnt   <= w_cnt;
                            r_state <= c_SHIFT;
                        end
                    end
                end
                c_SHIFT: begin
                    if (!r_mode) begin
                        // normalise until the hidden bit reaches bit 31
                        if (r_mag[31]) begin
                            out_data    <= {r_sign, r_exp, r_mag[30:8]};
                            out_inexact <= |r_mag[7:0];
                            out_invalid <= 1'b0;
                            r_state     <= c_DONE;
                        end else begin
                            r_mag <= {r_mag[30:0], 1'b0};
                            r_exp <= r_exp - 8'd1;
                        end
                    end else begin
                        if (r_cnt != 5'd0) begin
                            r_sticky <= r_sticky | r_mag[0];
                            r_mag    <= {1'b0, r_mag[31:1]};
                            r_cnt    <= r_cnt - 5'd1;
                        end else begin
                            out_data    <= r_sign ? w_neg_mag : r_mag;
                            out_inexact <= r_sticky;
                            out_invalid <= 1'b0;
                            r_state     <= c_DONE;
                        end
                    end
                end
                c_DONE: begin
                    if (out_ready) begin
                        r_state <= c_IDLE;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fp_int_converter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp_int_converter
// Description : Self-checking bench for fp_int_converter with a numeric model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_int_converter;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        mode;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_inexact;
    logic        out_invalid;

    int checks;
    int failures;

    fp_int_converter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .mode       (mode),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_inexact(out_inexact),
        .out_invalid(out_invalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Latency is counted in edges after the accept edge; immediate cases are 0.
    function automatic void model(input logic m, input logic [31:0] d,
                                  output logic [31:0] r, output logic inx,
                                  output logic inv, output int lat);
        longint mag;
        longint val;
        int     p;
        int     e;
        longint f;
        logic   s;
        r = 32'd0; inx = 1'b0; inv = 1'b0; lat = 0;
        if (!m) begin
            if (d != 32'd0) begin
                mag = d[31] ? (longint'(64'h1_0000_0000) - longint'(d)) : longint'(d);
                p = 0;
                for (int i = 0; i < 32; i++) if (mag[i]) p = i;
                if (p >= 23) begin
                    f   = (mag >> (p - 23)) & 64'h7F_FFFF;
                    inx = (mag & ((64'd1 << (p - 23)) - 1)) != 0;
                end else begin
                    f = (mag << (23 - p)) & 64'h7F_FFFF;
                end
                r   = {d[31], 8'(127 + p), f[22:0]};
                lat = 32 - p;
            end
        end else begin
            s = d[31];
            e = int'(d[30:23]);
            f = longint'(d[22:0]);
            if (e == 255 && f != 0) begin
                r = 32'h8000_0000; inv = 1'b1;
            end else if (s && e == 158 && f == 0) begin
                r = 32'h8000_0000;
            end else if (e >= 158) begin
                r = s ? 32'h8000_0000 : 32'h7FFF_FFFF; inv = 1'b1;
            end else if (e < 127) begin
                inx = (e != 0) || (f != 0);
            end else begin
                mag = (64'd1 << 23) | f;
                if (e >= 150) begin
                    val = mag << (e - 150);
                end else begin
                    val = mag >> (150 - e);
                    inx = (mag & ((64'd1 << (150 - e)) - 1)) != 0;
                end
                val = s ? -val : val;
                r   = val[31:0];
                lat = 159 - e;
            end
        end
    endfunction

    // Drives one request with out_ready high; returns captured result and latency.
    task automatic run_req(input logic m, input logic [31:0] d,
                           output logic [31:0] rd, output logic rx, output logic rv,
                           output int lat, output logic to);
        int n;
        to = 1'b0;
        in_valid = 1'b1; mode = m; in_data = d;
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1; n++;
        end
        if (!in_ready) to = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        if (!out_valid) to = 1'b1;
        rd = out_data; rx = out_inexact; rv = out_invalid;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 32'd0 || out_inexact !== 1'b0 ||
            out_invalid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset: got v=%b d=%h x=%b i=%b rdy=%b, want 0 0 0 0 1",
                     out_valid, out_data, out_inexact, out_invalid, in_ready);
        end
    endtask

    task automatic test_directed();
        logic        vm   [12] = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1};
        logic [31:0] vd   [12] = '{32'h0000_0001, 32'h8000_0000, 32'h0000_0000,
                                   32'h0100_0001, 32'hFFFF_FFFF, 32'h4049_0FDB,
                                   32'hC2F6_0000, 32'h3F00_0000, 32'h4F00_0000,
                                   32'hCF00_0000, 32'h7FC0_0000, 32'hFF80_0000};
        logic [31:0] vr   [12] = '{32'h3F80_0000, 32'hCF00_0000, 32'h0000_0000,
                                   32'h4B80_0000, 32'hBF80_0000, 32'h0000_0003,
                                   32'hFFFF_FF85, 32'h0000_0000, 32'h7FFF_FFFF,
                                   32'h8000_0000, 32'h8000_0000, 32'h8000_0000};
        logic        vx   [12] = '{0, 0, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0};
        logic        vi   [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1};
        int          vl   [12] = '{32, 1, 0, 8, 32, 31, 26, 0, 0, 0, 0, 0};
        logic [31:0] rd;
        logic        rx, rv, to;
        int          lat;
        for (int k = 0; k < 12; k++) begin
            run_req(vm[k], vd[k], rd, rx, rv, lat, to);
            checks++;
            if (to || rd !== vr[k] || rx !== vx[k] || rv !== vi[k] || lat != vl[k]) begin
                failures++;
                $display("FAIL directed[%0d] in=%h: got d=%h x=%b i=%b lat=%0d to=%b, want d=%h x=%b i=%b lat=%0d",
                         k, vd[k], rd, rx, rv, lat, to, vr[k], vx[k], vi[k], vl[k]);
            end
        end
    endtask

    task automatic test_random(input logic m, input int count);
        logic [31:0] d, rd, er;
        logic        rx, rv, to, ex, ei;
        int          lat, el;
        for (int k = 0; k < count; k++) begin
            if (!m) begin
                d = $urandom >> $urandom_range(0, 31);
                if ($urandom_range(0, 1) == 1) d = -d;
                if ($urandom_range(0, 15) == 0) d = 32'd0;
            end else begin
                d = {1'($urandom), 8'($urandom_range(118, 162)), 23'($urandom)};
                case ($urandom_range(0, 9))
                    0: d[30:23] = 8'hFF;
                    1: d[30:23] = 8'h00;
                    2: d[30:23] = 8'd158;
                    default: ;
                endcase
            end
            model(m, d, er, ex, ei, el);
            run_req(m, d, rd, rx, rv, lat, to);
            checks++;
            if (to || rd !== er || rx !== ex || rv !== ei || lat != el) begin
                failures++;
                $display("FAIL random mode=%b in=%h: got d=%h x=%b i=%b lat=%0d to=%b, want d=%h x=%b i=%b lat=%0d",
                         m, d, rd, rx, rv, lat, to, er, ex, ei, el);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] held;
        logic        hx, hv;
        int          n;
        out_ready = 1'b0;
        in_valid = 1'b1; mode = 1'b0; in_data = 32'h0100_0001;
        @(posedge clk); #1;
        mode = 1'b1; in_data = 32'hC2F6_0000;
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk); #1; n++;
        end
        checks++;
        if (!out_valid || out_data !== 32'h4B80_0000 || out_inexact !== 1'b1) begin
            failures++;
            $display("FAIL bp_first: got v=%b d=%h x=%b, want 1 4b800000 1",
                     out_valid, out_data, out_inexact);
        end
        held = out_data; hx = out_inexact; hv = out_invalid;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== held ||
                out_inexact !== hx || out_invalid !== hv) begin
                failures++;
                $display("FAIL bp_hold[%0d]: got v=%b rdy=%b d=%h x=%b i=%b, want 1 0 %h %b %b",
                         c, out_valid, in_ready, out_data, out_inexact, out_invalid, held, hx, hv);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_release: got v=%b rdy=%b, want 0 1", out_valid, in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk); #1; n++;
        end
        checks++;
        if (!out_valid || out_data !== 32'hFFFF_FF85 || out_inexact !== 1'b0 || n != 26) begin
            failures++;
            $display("FAIL bp_second: got v=%b d=%h x=%b lat=%0d, want 1 ffffff85 0 26",
                     out_valid, out_data, out_inexact, n);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_shift();
        logic [31:0] rd;
        logic        rx, rv, to;
        int          lat;
        in_valid = 1'b1; mode = 1'b0; in_data = 32'h0000_0001;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 32'd0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid: got v=%b d=%h rdy=%b, want 0 00000000 1",
                     out_valid, out_data, in_ready);
        end
        run_req(1'b1, 32'h4049_0FDB, rd, rx, rv, lat, to);
        checks++;
        if (to || rd !== 32'd3 || rx !== 1'b1 || rv !== 1'b0 || lat != 31) begin
            failures++;
            $display("FAIL reset_fresh: got d=%h x=%b i=%b lat=%0d to=%b, want 00000003 1 0 31",
                     rd, rx, rv, lat, to);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        in_valid = 1'b1; mode = 1'b0; in_data = 32'h8000_0000;
        @(posedge clk); #1;
        mode = 1'b1; in_data = 32'h4F00_0000;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'hCF00_0000) begin
            failures++;
            $display("FAIL b2b_first: got v=%b d=%h, want 1 cf000000", out_valid, out_data);
        end
        @(posedge clk); #1;
        n = 0;
        // handshake edge, then the held request is accepted on the following edge
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h7FFF_FFFF || out_invalid !== 1'b1) begin
            failures++;
            $display("FAIL b2b_second: got v=%b d=%h i=%b, want 1 7fffffff 1",
                     out_valid, out_data, out_invalid);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        checks = 0; failures = 0;
        rst_n = 1'b0; in_valid = 1'b0; mode = 1'b0; in_data = 32'd0; out_ready = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_directed();
        test_random(1'b0, 40);
        test_random(1'b1, 40);
        test_backpressure();
        test_reset_mid_shift();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
